// File: rtl/des_fp_out.sv
// DES output stage: pre-output swap, final permutation (IP^-1), 8-byte MSB-first stream.
// Optional self-check (IP applied to the held block) is enabled by DES_FP_SELFCHECK_EN.
module des_fp_out #(
  parameter bit LR_SWAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_l,
  input  logic [31:0] in_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic        busy
`ifdef DES_FP_SELFCHECK_EN
  ,
  output logic        check_err
`endif
);

  // Output DES position k (1-based, table entry k-1) takes pre-output position FP_TAB[k-1].
  localparam logic [6:0] FP_TAB [0:63] = '{
    7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
    7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
    7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
    7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
    7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
    7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
    7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
    7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
  };

  function automatic logic [63:0] fp_perm(input logic [63:0] p);
    logic [63:0] f;
    logic [6:0]  src;
    f = 64'h0;
    for (int k = 0; k < 64; k++) begin
      src = 7'd64 - FP_TAB[k];
      f[63-k] = p[src[5:0]];
    end
    return f;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [63:0] f, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = f[63:56];
      3'd1:    b = f[55:48];
      3'd2:    b = f[47:40];
      3'd3:    b = f[39:32];
      3'd4:    b = f[31:24];
      3'd5:    b = f[23:16];
      3'd6:    b = f[15:8];
      default: b = f[7:0];
    endcase
    return b;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state_r;
  logic [2:0]  cnt_r;
  logic [63:0] f_r;
  logic        out_valid_r;
  logic [7:0]  out_byte_r;
  logic        out_last_r;
  logic        busy_r;
  logic        in_ready_s;
  logic        accept_s;
  logic [63:0] pre_s;
  logic [63:0] fp_s;

  assign pre_s    = LR_SWAP ? {in_r, in_l} : {in_l, in_r};
  assign fp_s     = fp_perm(pre_s);
  assign accept_s = in_valid && in_ready_s;

  // Ready: always in IDLE, otherwise only when the last byte leaves this cycle.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      IDLE:    in_ready_s = 1'b1;
      SEND:    in_ready_s = (cnt_r == 3'd7) && out_ready;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Handshake FSM, byte counter, held block and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      f_r         <= 64'h0;
      out_valid_r <= 1'b0;
      out_byte_r  <= 8'h00;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else if (accept_s) begin
      state_r     <= SEND;
      cnt_r       <= 3'd0;
      f_r         <= fp_s;
      out_valid_r <= 1'b1;
      out_byte_r  <= fp_s[63:56];
      out_last_r  <= 1'b0;
      busy_r      <= 1'b1;
    end else if ((state_r == SEND) && out_ready) begin
      if (cnt_r != 3'd7) begin
        cnt_r      <= cnt_r + 3'd1;
        out_byte_r <= byte_sel(f_r, cnt_r + 3'd1);
        out_last_r <= (cnt_r == 3'd6);
      end else begin
        state_r     <= IDLE;
        cnt_r       <= 3'd0;
        out_valid_r <= 1'b0;
        out_byte_r  <= 8'h00;
        out_last_r  <= 1'b0;
        busy_r      <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_byte  = out_byte_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;

`ifdef DES_FP_SELFCHECK_EN
  function automatic logic [63:0] ip_perm(input logic [63:0] f);
    logic [63:0] p;
    logic [6:0]  dst;
    p = 64'h0;
    for (int k = 0; k < 64; k++) begin
      dst = 7'd64 - FP_TAB[k];
      p[dst[5:0]] = f[63-k];
    end
    return p;
  endfunction

  logic [63:0] p_r;
  logic        check_err_r;

  // The held block is re-checked every SEND cycle, so a later upset of F is also caught.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_r         <= 64'h0;
      check_err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        p_r <= pre_s;
      end
      if ((state_r == SEND) && (ip_perm(f_r) != p_r)) begin
        check_err_r <= 1'b1;
      end
    end
  end

  assign check_err = check_err_r;
`endif

endmodule

// File: tb/tb_des_fp_out.sv
// Self-checking bench for des_fp_out: directed scenarios plus random traffic against a
// block-level model (FP table applied with plain arithmetic, byte queue per held block).
module tb_des_fp_out;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_l;
  logic [31:0] in_r;

  logic        in_ready,  out_valid,  out_last,  busy;
  logic [7:0]  out_byte;
  logic        in_ready0, out_valid0, out_last0, busy0;
  logic [7:0]  out_byte0;
`ifdef DES_FP_SELFCHECK_EN
  logic        check_err, check_err0;
`endif

  des_fp_out #(.LR_SWAP(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_l(in_l), .in_r(in_r), .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_last(out_last), .busy(busy)
`ifdef DES_FP_SELFCHECK_EN
    , .check_err(check_err)
`endif
  );

  des_fp_out #(.LR_SWAP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_l(in_l), .in_r(in_r), .out_valid(out_valid0), .out_ready(out_ready),
    .out_byte(out_byte0), .out_last(out_last0), .busy(busy0)
`ifdef DES_FP_SELFCHECK_EN
    , .check_err(check_err0)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int fp_tab [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41, 9,  49, 17, 57, 25
  };

  // Model state: pending input blocks and the block currently being streamed.
  logic [63:0] pend_q [$];
  bit          have;
  int          idx;
  logic [63:0] cur1, cur0;
  logic [63:0] cap1, cap0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // DES position n lives at vector index 64-n; output k takes pre-output position fp_tab[k-1].
  function automatic logic [63:0] ref_fp(input logic [31:0] l, input logic [31:0] r, input bit swap);
    logic [63:0] p;
    logic [63:0] f;
    p = swap ? {r, l} : {l, r};
    f = 64'h0;
    for (int k = 1; k <= 64; k++) f[64-k] = p[64-fp_tab[k-1]];
    return f;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(1'b0));
    chk({tag, "_out_byte"},  64'(out_byte),  64'(8'h00));
    chk({tag, "_out_last"},  64'(out_last),  64'(1'b0));
    chk({tag, "_busy"},      64'(busy),      64'(1'b0));
    chk({tag, "_in_ready"},  64'(in_ready),  64'(1'b1));
    chk({tag, "_busy_swap0"}, 64'(busy0),    64'(1'b0));
  endtask

  // mode 0: ready held high; 1: random valid/ready; 2: 3-cycle stall at byte 2.
  task automatic stream(input int mode, input int abort_at);
    int guard = 0;
    int taken = 0;
    int stalls = 0;
    bit fire, rdy_exp;
    logic [7:0] e1, e0;
    logic [63:0] blk;
    have = 1'b0;
    idx  = 0;
    cap1 = 64'h0;
    cap0 = 64'h0;
    while ((pend_q.size() > 0 || have) && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (pend_q.size() > 0 && (mode != 1 || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        {in_l, in_r} = pend_q[0];
      end else begin
        in_valid = 1'b0;
        in_l = $urandom;
        in_r = $urandom;
      end
      if (mode == 1) out_ready = ($urandom_range(0, 2) != 0);
      else if (mode == 2 && have && idx == 2 && stalls < 3) begin
        out_ready = 1'b0;
        stalls++;
      end else out_ready = 1'b1;
      #1;
      e1 = have ? cur1[63-8*idx -: 8] : 8'h00;
      e0 = have ? cur0[63-8*idx -: 8] : 8'h00;
      rdy_exp = !have || (idx == 7 && out_ready);
      chk("out_valid",   64'(out_valid), 64'(have));
      chk("out_byte",    64'(out_byte),  64'(e1));
      chk("out_last",    64'(out_last),  64'(have && idx == 7));
      chk("busy",        64'(busy),      64'(have));
      chk("in_ready",    64'(in_ready),  64'(rdy_exp));
      chk("swap0_byte",  64'(out_byte0), 64'(e0));
      chk("swap0_ready", 64'(in_ready0), 64'(rdy_exp));
      fire = have && out_ready;
      if (fire) begin
        cap1 = {cap1[55:0], e1};
        cap0 = {cap0[55:0], e0};
        taken++;
        if (idx < 7) idx++;
        else have = 1'b0;
      end
      if (in_valid && rdy_exp) begin
        blk  = pend_q.pop_front();
        cur1 = ref_fp(blk[63:32], blk[31:0], 1'b1);
        cur0 = ref_fp(blk[63:32], blk[31:0], 1'b0);
        have = 1'b1;
        idx  = 0;
      end
      if (abort_at > 0 && taken == abort_at) break;
    end
    if (abort_at == 0) chk("stream_drained", 64'(have || pend_q.size() > 0), 64'(1'b0));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_l = 32'h0;
    in_r = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("reset");

    // Known answer
    pend_q.push_back({32'h43423234, 32'h0A4CD995});
    stream(0, 0);
    chk("kat_bytes", cap1, 64'h85E813540F0AB405);

    // Single bit at DES position 1 of the pre-output (lands in byte 8, bit 0x40)
    pend_q.push_back({32'h80000000, 32'h00000000});
    stream(0, 0);
    chk("single_bit_swap0", cap0, 64'h0000000000000040);

    // Back-to-back blocks
    pend_q.push_back({32'h01234567, 32'h89ABCDEF});
    pend_q.push_back({32'hFEDCBA98, 32'h76543210});
    stream(0, 0);

    // Backpressure at byte 2
    pend_q.push_back({32'hDEADBEEF, 32'hC0FFEE00});
    stream(2, 0);

    // Reset after byte 4 is taken
    pend_q.push_back({32'h13579BDF, 32'h2468ACE0});
    stream(0, 5);
    pend_q.delete();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("mid_reset");
    pend_q.push_back({32'hA5A5A5A5, 32'h5A5A5A5A});
    stream(0, 0);

    // Random traffic
    for (int i = 0; i < 150; i++) pend_q.push_back({$urandom, $urandom});
    stream(1, 0);

`ifdef DES_FP_SELFCHECK_EN
    begin
      logic [63:0] saved;
      for (int i = 0; i < 1000; i++) pend_q.push_back({$urandom, $urandom});
      stream(0, 0);
      chk("selfcheck_clean", 64'(check_err), 64'(1'b0));
      @(negedge clk);
      in_valid = 1'b1;
      {in_l, in_r} = {$urandom, $urandom};
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      saved = dut.f_r;
      force dut.f_r = saved ^ 64'h0000000000010000;
      repeat (2) @(negedge clk);
      release dut.f_r;
      chk("selfcheck_detect", 64'(check_err), 64'(1'b1));
      repeat (4) @(negedge clk);
      chk("selfcheck_sticky", 64'(check_err), 64'(1'b1));
      chk("selfcheck_other_clean", 64'(check_err0), 64'(1'b0));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("selfcheck_reset", 64'(check_err), 64'(1'b0));
      check_idle("selfcheck_idle");
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
